// File: rtl/fft_pingpong_mem_if.sv
// fft_pingpong_mem_if: stream, core-control and compute-bank signals of the ping-pong FFT memory
//  slave  : memory side (drives in_ready, out_*, core_start/busy, rdata*, bank_sel, err_collision)
//  master : environment side (drives in_*, out_ready, core_done, raddr*, we*, waddr*, wdata*)
interface fft_pingpong_mem_if #(parameter int N = 8, parameter int WIDTH = 12);
  localparam int AW = $clog2(N);
  logic in_valid, in_ready, out_valid, out_ready;
  logic signed [WIDTH-1:0] in_re, in_im, out_re, out_im;
  logic core_start, core_done, core_busy, bank_sel, err_collision;
  logic [AW-1:0] raddr1, raddr2, waddr1, waddr2;
  logic we1, we2;
  logic signed [WIDTH-1:0] rdata1_re, rdata1_im, rdata2_re, rdata2_im;
  logic signed [WIDTH-1:0] wdata1_re, wdata1_im, wdata2_re, wdata2_im;
  modport slave (
    input  in_valid, in_re, in_im, out_ready, core_done,
    input  raddr1, raddr2, we1, we2, waddr1, waddr2,
    input  wdata1_re, wdata1_im, wdata2_re, wdata2_im,
    output in_ready, out_valid, out_re, out_im, core_start, core_busy,
    output rdata1_re, rdata1_im, rdata2_re, rdata2_im, bank_sel, err_collision
  );
  modport master (
    output in_valid, in_re, in_im, out_ready, core_done,
    output raddr1, raddr2, we1, we2, waddr1, waddr2,
    output wdata1_re, wdata1_im, wdata2_re, wdata2_im,
    input  in_ready, out_valid, out_re, out_im, core_start, core_busy,
    input  rdata1_re, rdata1_im, rdata2_re, rdata2_im, bank_sel, err_collision
  );
endinterface

// File: rtl/fft_pingpong_mem.sv
// fft_pingpong_mem: double-buffered FFT sample memory with IO streaming FSM and bank-swap controller
//  clk, rst : clock and asynchronous active-high reset
//  bus      : slave modport carrying the load/unload streams, core handshake and compute-bank ports
module fft_pingpong_mem #(
  parameter int N          = 8,
  parameter int WIDTH      = 12,
  parameter int FRACTION   = 8,
  parameter int IN_BITREV  = 1,
  parameter int OUT_BITREV = 0
) (
  input logic               clk,
  input logic               rst,
  fft_pingpong_mem_if.slave bus
);
  localparam int AW = $clog2(N);
  if (N < 4 || (N & (N - 1)) != 0 || FRACTION >= WIDTH) begin : g_bad_params
    $error("fft_pingpong_mem: N must be a power of 2 >= 4 and FRACTION < WIDTH");
  end
  typedef enum logic [1:0] {LOAD, FULL, UNLOAD} io_state_t;
  io_state_t state_q, state_d;
  logic [AW-1:0] lcnt_q, lcnt_d, ucnt_q, ucnt_d, laddr, uaddr;
  logic bank_q, bank_d, busy_q, busy_d, start_q, start_d, res_q, res_d, err_q, err_d;
  logic io_bank, in_fire, out_fire, swap, cwe1, cwe2;
  logic signed [WIDTH-1:0] re_q [2][N];
  logic signed [WIDTH-1:0] im_q [2][N];
  function automatic logic [AW-1:0] bitrev(input logic [AW-1:0] a);
    for (int i = 0; i < AW; i++) bitrev[i] = a[AW-1-i];
  endfunction
  assign io_bank  = ~bank_q;
  assign in_fire  = state_q == LOAD && bus.in_valid;
  assign out_fire = state_q == UNLOAD && bus.out_ready;
  assign swap     = state_q == FULL && !busy_q;
  assign cwe1     = busy_q && bus.we1;
  assign cwe2     = busy_q && bus.we2;
  assign laddr    = IN_BITREV != 0 ? bitrev(lcnt_q) : lcnt_q;
  assign uaddr    = OUT_BITREV != 0 ? bitrev(ucnt_q) : ucnt_q;
  assign bus.in_ready      = state_q == LOAD;
  assign bus.out_valid     = state_q == UNLOAD;
  assign bus.out_re        = re_q[io_bank][uaddr];
  assign bus.out_im        = im_q[io_bank][uaddr];
  assign bus.rdata1_re     = re_q[bank_q][bus.raddr1];
  assign bus.rdata1_im     = im_q[bank_q][bus.raddr1];
  assign bus.rdata2_re     = re_q[bank_q][bus.raddr2];
  assign bus.rdata2_im     = im_q[bank_q][bus.raddr2];
  assign bus.core_start    = start_q;
  assign bus.core_busy     = busy_q;
  assign bus.bank_sel      = bank_q;
  assign bus.err_collision = err_q;
  // Counters wrap on their own because N is a power of 2.
  always_comb begin
    state_d = state_q;
    lcnt_d  = in_fire ? lcnt_q + 1'b1 : lcnt_q;
    ucnt_d  = out_fire ? ucnt_q + 1'b1 : ucnt_q;
    bank_d  = bank_q;
    busy_d  = busy_q;
    start_d = 1'b0;
    res_d   = res_q;
    err_d   = err_q | (cwe1 && cwe2 && bus.waddr1 == bus.waddr2);
    if (in_fire && &lcnt_q) state_d = FULL;
    if (out_fire && &ucnt_q) state_d = LOAD;
    // swap needs !busy_q and core_done needs busy_q, so the two never coincide
    if (swap) begin
      bank_d  = ~bank_q;
      start_d = 1'b1;
      busy_d  = 1'b1;
      res_d   = 1'b0;
      state_d = res_q ? UNLOAD : LOAD;
    end
    if (bus.core_done && busy_q) begin
      busy_d = 1'b0;
      res_d  = 1'b1;
    end
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= LOAD;
      lcnt_q  <= '0;
      ucnt_q  <= '0;
      bank_q  <= 1'b0;
      busy_q  <= 1'b0;
      start_q <= 1'b0;
      res_q   <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      lcnt_q  <= lcnt_d;
      ucnt_q  <= ucnt_d;
      bank_q  <= bank_d;
      busy_q  <= busy_d;
      start_q <= start_d;
      res_q   <= res_d;
      err_q   <= err_d;
    end
  end
  // Port 2 is written after port 1 so it wins an address collision.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int b = 0; b < 2; b++)
        for (int i = 0; i < N; i++) begin
          re_q[b][i] <= '0;
          im_q[b][i] <= '0;
        end
    end else begin
      if (in_fire) begin
        re_q[io_bank][laddr] <= bus.in_re;
        im_q[io_bank][laddr] <= bus.in_im;
      end
      if (cwe1) begin
        re_q[bank_q][bus.waddr1] <= bus.wdata1_re;
        im_q[bank_q][bus.waddr1] <= bus.wdata1_im;
      end
      if (cwe2) begin
        re_q[bank_q][bus.waddr2] <= bus.wdata2_re;
        im_q[bank_q][bus.waddr2] <= bus.wdata2_im;
      end
    end
  end
endmodule

// File: tb/tb_fft_pingpong_mem.sv
// tb_fft_pingpong_mem: directed table-driven bench for the ping-pong FFT memory (N=8, IN_BITREV=1)
module tb_fft_pingpong_mem;
  logic clk = 1'b0, rst = 1'b1;
  int errors = 0, checks = 0;
  typedef struct {int addr; int k;} rd_t;
  rd_t tbl [8];
  int exp_re [8], exp_im [8];
  fft_pingpong_mem_if #(.N(8), .WIDTH(12)) bus ();
  fft_pingpong_mem #(.N(8), .WIDTH(12), .FRACTION(8), .IN_BITREV(1), .OUT_BITREV(0)) dut (
    .clk(clk), .rst(rst), .bus(bus)
  );
  always #5 clk = ~clk;
  task automatic chk(input string nm, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask
  // Load beat k carries re=base+mul*k, im=isg*k.
  task automatic load_frame(input int n, input int base, input int mul, input int isg);
    for (int k = 0; k < n; k++) begin
      @(negedge clk);
      #1 chk("load_in_ready", int'(bus.in_ready), 1);
      bus.in_valid = 1'b1;
      bus.in_re = 12'(base + mul * k);
      bus.in_im = 12'(isg * k);
    end
    @(negedge clk);
    bus.in_valid = 1'b0;
  endtask
  // Read every compute-bank address on both ports; address a holds load beat tbl.k.
  task automatic read_tbl(input string nm, input int base, input int mul, input int isg);
    for (int i = 0; i < 8; i++) begin
      bus.raddr1 = 3'(tbl[i].addr);
      bus.raddr2 = 3'(tbl[7-i].addr);
      #1;
      chk({nm, "_rd1_re"}, int'(bus.rdata1_re), base + mul * tbl[i].k);
      chk({nm, "_rd1_im"}, int'(bus.rdata1_im), isg * tbl[i].k);
      chk({nm, "_rd2_re"}, int'(bus.rdata2_re), base + mul * tbl[7-i].k);
      chk({nm, "_rd2_im"}, int'(bus.rdata2_im), isg * tbl[7-i].k);
    end
  endtask
  task automatic core_wr(input logic e1, input int a1, input int r1, input int i1,
                         input logic e2, input int a2, input int r2, input int i2);
    @(negedge clk);
    bus.we1 = e1; bus.waddr1 = 3'(a1); bus.wdata1_re = 12'(r1); bus.wdata1_im = 12'(i1);
    bus.we2 = e2; bus.waddr2 = 3'(a2); bus.wdata2_re = 12'(r2); bus.wdata2_im = 12'(i2);
    @(negedge clk);
    bus.we1 = 1'b0;
    bus.we2 = 1'b0;
  endtask
  task automatic pulse_done();
    @(negedge clk);
    bus.core_done = 1'b1;
    @(negedge clk);
    bus.core_done = 1'b0;
  endtask
  initial begin
    int beats, cyc;
    tbl = '{'{0, 0}, '{1, 4}, '{2, 2}, '{3, 6}, '{4, 1}, '{5, 5}, '{6, 3}, '{7, 7}};
    bus.in_valid = 0; bus.in_re = '0; bus.in_im = '0; bus.out_ready = 0; bus.core_done = 0;
    bus.raddr1 = '0; bus.raddr2 = '0; bus.we1 = 0; bus.we2 = 0; bus.waddr1 = '0; bus.waddr2 = '0;
    bus.wdata1_re = '0; bus.wdata1_im = '0; bus.wdata2_re = '0; bus.wdata2_im = '0;
    repeat (2) @(negedge clk);
    #1;
    chk("rst_in_ready", int'(bus.in_ready), 1);
    chk("rst_out_valid", int'(bus.out_valid), 0);
    chk("rst_core_busy", int'(bus.core_busy), 0);
    chk("rst_core_start", int'(bus.core_start), 0);
    chk("rst_bank_sel", int'(bus.bank_sel), 0);
    chk("rst_err", int'(bus.err_collision), 0);
    read_tbl("rst", 0, 0, 0);
    rst = 1'b0;
    // Frame 1: swap with no pending results, core_start two cycles after beat 7
    load_frame(8, 0, 16, -1);
    #1;
    chk("f1_full_in_ready", int'(bus.in_ready), 0);
    chk("f1_start_early", int'(bus.core_start), 0);
    @(negedge clk);
    #1;
    chk("f1_core_start", int'(bus.core_start), 1);
    chk("f1_bank_sel", int'(bus.bank_sel), 1);
    chk("f1_core_busy", int'(bus.core_busy), 1);
    chk("f1_back_to_load", int'(bus.in_ready), 1);
    chk("f1_out_valid", int'(bus.out_valid), 0);
    read_tbl("f1", 0, 16, -1);
    @(negedge clk);
    #1 chk("f1_start_pulse_end", int'(bus.core_start), 0);
    // Core writes results into bank 1
    for (int i = 0; i < 8; i += 2) core_wr(1, i, 'h100 + i, i, 1, i + 1, 'h101 + i, i + 1);
    bus.raddr1 = 3'd0;
    bus.raddr2 = 3'd7;
    #1;
    chk("f1_res_rd0", int'(bus.rdata1_re), 'h100);
    chk("f1_res_rd7", int'(bus.rdata2_im), 7);
    pulse_done();
    #1 chk("f1_done_busy", int'(bus.core_busy), 0);
    core_wr(1, 0, 'h7ff, 0, 0, 0, 0, 0);
    bus.raddr1 = 3'd0;
    #1 chk("idle_write_ignored", int'(bus.rdata1_re), 'h100);
    // Frame 2: swap straight into UNLOAD of frame-1 results
    load_frame(8, 'h40, 1, 1);
    #1;
    chk("f2_full_in_ready", int'(bus.in_ready), 0);
    chk("f2_full_out_valid", int'(bus.out_valid), 0);
    @(negedge clk);
    #1;
    chk("f2_core_start", int'(bus.core_start), 1);
    chk("f2_bank_sel", int'(bus.bank_sel), 0);
    bus.raddr1 = 3'd1;
    #1 chk("f2_compute_rd1", int'(bus.rdata1_re), 'h44);
    for (int i = 0; i < 8; i++) begin
      chk("u1_out_valid", int'(bus.out_valid), 1);
      chk("u1_in_ready", int'(bus.in_ready), 0);
      chk("u1_out_re", int'(bus.out_re), 'h100 + i);
      chk("u1_out_im", int'(bus.out_im), i);
      bus.out_ready = 1'b1;
      @(negedge clk);
      #1;
    end
    bus.out_ready = 1'b0;
    chk("u1_end_out_valid", int'(bus.out_valid), 0);
    chk("u1_end_in_ready", int'(bus.in_ready), 1);
    // Core results for frame 2 with a port collision at address 5
    for (int i = 0; i < 8; i++) begin
      exp_re[i] = (i == 5) ? 'h022 : 'h200 + i;
      exp_im[i] = -i;
      if (i != 5) core_wr(1, i, 'h200 + i, -i, 0, 0, 0, 0);
    end
    chk("pre_collision_err", int'(bus.err_collision), 0);
    core_wr(1, 5, 'h011, 7, 1, 5, 'h022, -5);
    bus.raddr1 = 3'd5;
    #1;
    chk("collision_data", int'(bus.rdata1_re), 'h022);
    chk("collision_err", int'(bus.err_collision), 1);
    // Frame 3 fully loaded while the core is busy: hold in FULL
    load_frame(8, 'h500, 1, 1);
    for (int c = 0; c < 3; c++) begin
      #1;
      chk("f3_hold_in_ready", int'(bus.in_ready), 0);
      chk("f3_hold_start", int'(bus.core_start), 0);
      chk("f3_hold_bank", int'(bus.bank_sel), 0);
      @(negedge clk);
    end
    pulse_done();
    #1;
    chk("f3_done_busy", int'(bus.core_busy), 0);
    chk("f3_done_no_swap", int'(bus.bank_sel), 0);
    chk("f3_done_out_valid", int'(bus.out_valid), 0);
    @(negedge clk);
    #1;
    chk("f3_core_start", int'(bus.core_start), 1);
    chk("f3_bank_sel", int'(bus.bank_sel), 1);
    chk("err_sticky", int'(bus.err_collision), 1);
    bus.raddr1 = 3'd1;
    #1 chk("f3_compute_rd1", int'(bus.rdata1_re), 'h504);
    // Stalled unload with out_ready pattern 1,0,0,...
    beats = 0;
    cyc = 0;
    while (beats < 8 && cyc < 60) begin
      chk("u2_out_valid", int'(bus.out_valid), 1);
      chk("u2_in_ready", int'(bus.in_ready), 0);
      chk("u2_out_re", int'(bus.out_re), exp_re[beats]);
      chk("u2_out_im", int'(bus.out_im), exp_im[beats]);
      bus.out_ready = (cyc % 3 == 0);
      if (bus.out_ready) beats++;
      cyc++;
      @(negedge clk);
      #1;
    end
    bus.out_ready = 1'b0;
    chk("u2_beats", beats, 8);
    chk("u2_end_out_valid", int'(bus.out_valid), 0);
    chk("u2_end_in_ready", int'(bus.in_ready), 1);
    // Asynchronous reset in the middle of a partial load
    load_frame(3, 'h70, 1, 1);
    rst = 1'b1;
    #1;
    chk("mid_rst_in_ready", int'(bus.in_ready), 1);
    chk("mid_rst_out_valid", int'(bus.out_valid), 0);
    chk("mid_rst_busy", int'(bus.core_busy), 0);
    chk("mid_rst_bank", int'(bus.bank_sel), 0);
    chk("mid_rst_err", int'(bus.err_collision), 0);
    read_tbl("mid_rst", 0, 0, 0);
    @(negedge clk);
    rst = 1'b0;
    load_frame(8, 'h300, 1, 1);
    @(negedge clk);
    #1;
    chk("f6_core_start", int'(bus.core_start), 1);
    chk("f6_bank_sel", int'(bus.bank_sel), 1);
    read_tbl("f6", 'h300, 1, 1);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
